// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU encodings, the decoded
// entry record held in each skid-buffer slot, and the buffer state type.
package rv32_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  typedef struct packed {
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [2:0]         br_funct3;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [RV_XLEN-1:0] imm;
    logic               alu_src_imm;
    logic               reg_write;
    logic               is_branch;
    logic               illegal;
    logic [RV_XLEN-1:0] pc;
  } decoded_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  // Writes to x0 are architecturally discarded, so never request them.
  function automatic logic rd_wen(input logic [4:0] rd);
    return (rd != 5'd0);
  endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational immediate extraction for the I/S/B/U/J instruction formats.
// Every immediate is sign-extended from instruction bit 31 to XLEN.
module rv32_imm_gen
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_s,
  output logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] imm_j
);

  logic signed [31:0] i32;
  logic signed [31:0] s32;
  logic signed [31:0] b32;
  logic signed [31:0] u32;
  logic signed [31:0] j32;

  assign i32 = {{20{instr[31]}}, instr[31:20]};
  assign s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u32 = {instr[31:12], 12'h000};
  assign j32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Signed size casts keep the sign when XLEN is wider than 32.
  assign imm_i = XLEN'(i32);
  assign imm_s = XLEN'(s32);
  assign imm_b = XLEN'(b32);
  assign imm_u = XLEN'(u32);
  assign imm_j = XLEN'(j32);

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode stage feeding the ALU. Instructions are decoded
// combinationally on entry and captured into a 2-entry FIFO skid buffer, so
// every output and in_ready come straight from flops.
module alu_decode_stage
  import rv32_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit ILLEGAL_PASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_br_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_alu_src_imm,
  output logic            out_reg_write,
  output logic            out_is_branch,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  logic [XLEN-1:0] imm_i_p0;
  logic [XLEN-1:0] imm_s_p0;
  logic [XLEN-1:0] imm_b_p0;
  logic [XLEN-1:0] imm_u_p0;
  logic [XLEN-1:0] imm_j_p0;

  decoded_t    dec_p0;
  decoded_t    ent0_p1;
  decoded_t    ent1_p1;
  skid_state_t state_q;
  skid_state_t state_d;
  logic        in_ready_q;
  logic        vld_p1;

  logic [6:0]  opc_p0;
  logic [2:0]  f3_p0;
  logic [6:0]  f7_p0;
  logic        legal_p0;
  logic        accept_p0;
  logic        store_p0;
  logic        pop_p1;
  logic        ent0_ld_dec;
  logic        ent0_ld_ent1;
  logic        ent1_ld_dec;

  rv32_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .imm_i (imm_i_p0),
    .imm_s (imm_s_p0),
    .imm_b (imm_b_p0),
    .imm_u (imm_u_p0),
    .imm_j (imm_j_p0)
  );

  // ---- stage p0: combinational decode of the incoming instruction ----
  assign opc_p0 = in_instr[6:0];
  assign f3_p0  = in_instr[14:12];
  assign f7_p0  = in_instr[31:25];

  // Map the raw instruction onto ALU controls and classify legality.
  always_comb begin
    dec_p0           = '0;
    dec_p0.br_funct3 = f3_p0;
    dec_p0.rs1       = in_instr[19:15];
    dec_p0.rs2       = in_instr[24:20];
    dec_p0.rd        = in_instr[11:7];
    dec_p0.pc        = RV_XLEN'(in_pc);
    legal_p0         = 1'b1;
    case (opc_p0)
      OPC_OP: begin
        dec_p0.funct3    = f3_p0;
        dec_p0.funct7    = f7_p0;
        dec_p0.reg_write = rd_wen(in_instr[11:7]);
        legal_p0 = (f7_p0 == F7_BASE) ||
                   ((f7_p0 == F7_ALT) && ((f3_p0 == ALU_ADD) || (f3_p0 == ALU_SR)));
      end
      OPC_OP_IMM: begin
        dec_p0.funct3      = f3_p0;
        dec_p0.funct7      = F7_BASE;
        dec_p0.alu_src_imm = 1'b1;
        dec_p0.reg_write   = rd_wen(in_instr[11:7]);
        dec_p0.imm         = RV_XLEN'(imm_i_p0);
        // Shifts carry only the 5-bit shamt; the upper field is a modifier.
        if (f3_p0 == ALU_SLL) begin
          dec_p0.imm = {{(RV_XLEN-5){1'b0}}, in_instr[24:20]};
          legal_p0   = (f7_p0 == F7_BASE);
        end else if (f3_p0 == ALU_SR) begin
          dec_p0.imm    = {{(RV_XLEN-5){1'b0}}, in_instr[24:20]};
          dec_p0.funct7 = f7_p0;
          legal_p0      = (f7_p0 == F7_BASE) || (f7_p0 == F7_ALT);
        end
      end
      OPC_LOAD, OPC_JALR: begin
        dec_p0.funct3      = ALU_ADD;
        dec_p0.alu_src_imm = 1'b1;
        dec_p0.reg_write   = rd_wen(in_instr[11:7]);
        dec_p0.imm         = RV_XLEN'(imm_i_p0);
      end
      OPC_STORE: begin
        dec_p0.funct3      = ALU_ADD;
        dec_p0.alu_src_imm = 1'b1;
        dec_p0.imm         = RV_XLEN'(imm_s_p0);
      end
      OPC_LUI: begin
        dec_p0.rs1         = 5'd0;
        dec_p0.funct3      = ALU_ADD;
        dec_p0.alu_src_imm = 1'b1;
        dec_p0.reg_write   = rd_wen(in_instr[11:7]);
        dec_p0.imm         = RV_XLEN'(imm_u_p0);
      end
      OPC_AUIPC: begin
        dec_p0.funct3      = ALU_ADD;
        dec_p0.alu_src_imm = 1'b1;
        dec_p0.reg_write   = rd_wen(in_instr[11:7]);
        dec_p0.imm         = RV_XLEN'(imm_u_p0);
      end
      OPC_JAL: begin
        dec_p0.funct3      = ALU_ADD;
        dec_p0.alu_src_imm = 1'b1;
        dec_p0.reg_write   = rd_wen(in_instr[11:7]);
        dec_p0.imm         = RV_XLEN'(imm_j_p0);
      end
      OPC_BRANCH: begin
        dec_p0.is_branch = 1'b1;
        dec_p0.imm       = RV_XLEN'(imm_b_p0);
        // Equality compares subtract; ordered compares reuse SLT/SLTU.
        case (f3_p0)
          3'b000, 3'b001: begin
            dec_p0.funct3 = ALU_ADD;
            dec_p0.funct7 = F7_ALT;
          end
          3'b100, 3'b101: dec_p0.funct3 = ALU_SLT;
          3'b110, 3'b111: dec_p0.funct3 = ALU_SLTU;
          default:        legal_p0      = 1'b0;
        endcase
      end
      default: legal_p0 = 1'b0;
    endcase
    if (in_instr[1:0] != 2'b11) legal_p0 = 1'b0;
    if (!legal_p0) begin
      dec_p0.illegal     = 1'b1;
      dec_p0.funct3      = 3'b000;
      dec_p0.funct7      = F7_BASE;
      dec_p0.reg_write   = 1'b0;
      dec_p0.is_branch   = 1'b0;
      dec_p0.alu_src_imm = 1'b0;
    end
  end

  // An accepted illegal instruction completes its handshake but is only
  // buffered when forwarding of illegal entries is enabled.
  assign accept_p0 = in_valid && in_ready_q;
  assign store_p0  = accept_p0 && (ILLEGAL_PASS || !dec_p0.illegal);
  assign pop_p1    = vld_p1 && out_ready;

  // ---- stage p1: skid buffer control and storage ----
  // Skid-buffer state plus the registered handshake flags derived from it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SKID_EMPTY;
      in_ready_q <= 1'b1;
      vld_p1     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != SKID_TWO);
      vld_p1     <= (state_d != SKID_EMPTY);
    end
  end

  // Occupancy transitions; flush overrides any same-cycle push or pop.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: if (store_p0) state_d = SKID_ONE;
        SKID_ONE: begin
          if (store_p0 && !pop_p1)      state_d = SKID_TWO;
          else if (pop_p1 && !store_p0) state_d = SKID_EMPTY;
        end
        SKID_TWO:   if (pop_p1) state_d = SKID_ONE;
        default:    state_d = SKID_EMPTY;
      endcase
    end
  end

  // Slot load enables: slot 0 is always the FIFO head presented downstream.
  always_comb begin
    ent0_ld_dec  = 1'b0;
    ent0_ld_ent1 = 1'b0;
    ent1_ld_dec  = 1'b0;
    if (!flush) begin
      case (state_q)
        SKID_EMPTY: ent0_ld_dec = store_p0;
        SKID_ONE: begin
          ent0_ld_dec = store_p0 && pop_p1;
          ent1_ld_dec = store_p0 && !pop_p1;
        end
        SKID_TWO:   ent0_ld_ent1 = pop_p1;
        default:    ent0_ld_dec = 1'b0;
      endcase
    end
  end

  // Slot storage; cleared on reset so the idle outputs read as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent0_p1 <= '0;
      ent1_p1 <= '0;
    end else begin
      if (ent0_ld_dec)       ent0_p1 <= dec_p0;
      else if (ent0_ld_ent1) ent0_p1 <= ent1_p1;
      if (ent1_ld_dec)       ent1_p1 <= dec_p0;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = vld_p1;
  assign out_funct3      = ent0_p1.funct3;
  assign out_funct7      = ent0_p1.funct7;
  assign out_br_funct3   = ent0_p1.br_funct3;
  assign out_rs1         = ent0_p1.rs1;
  assign out_rs2         = ent0_p1.rs2;
  assign out_rd          = ent0_p1.rd;
  assign out_imm         = XLEN'(ent0_p1.imm);
  assign out_alu_src_imm = ent0_p1.alu_src_imm;
  assign out_reg_write   = ent0_p1.reg_write;
  assign out_is_branch   = ent0_p1.is_branch;
  assign out_illegal     = ent0_p1.illegal;
  assign out_pc          = XLEN'(ent0_p1.pc);

endmodule
